sdram_client_arbiter: RTL

Responder side of the client SDRAM request protocol. It accepts level-held read/write requests from NUM_CLIENTS processing cores (0 = loader, 1 = mixer, 2 = pitch, 3 = recorder) and grants them round-robin, one transaction at a time. Each granted transaction is issued as an Avalon-MM master access to the SDRAM controller s1 port. Completion is returned to the requesting client as a one-cycle finished pulse.

---
 rtl/sdram_client_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sdram_client_arbiter.sv
// Round-robin arbiter that serialises level-held client read/write requests
// onto a single Avalon-MM master port, one transaction at a time.
module sdram_client_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_CLIENTS-1:0]        client_read,
    input  logic [NUM_CLIENTS-1:0]        client_write,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] client_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] client_writedata,
    output logic [DATA_W-1:0]             client_readdata,
    output logic [NUM_CLIENTS-1:0]        client_read_finished,
    output logic [NUM_CLIENTS-1:0]        client_write_finished,
    output logic                          rd_timeout,
    output logic [ADDR_W-1:0]             sdram_address,
    output logic [3:0]                    sdram_byteenable_n,
    output logic                          sdram_chipselect,
    output logic [DATA_W-1:0]             sdram_writedata,
    output logic                          sdram_read_n,
    output logic                          sdram_write_n,
    input  logic [DATA_W-1:0]             sdram_readdata,
    input  logic                          sdram_readdatavalid,
    input  logic                          sdram_waitrequest
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]             state;
    logic [IDX_W-1:0]       last;
    logic [IDX_W-1:0]       cur;
    logic [CNT_W-1:0]       wait_cnt;
    logic [NUM_CLIENTS-1:0] req;
    logic [IDX_W-1:0]       pick;
    logic                   pick_valid;

    // Walk offsets from farthest to nearest so the client closest after
    // `last` is the one left standing in `pick`.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        req        = client_read | client_write;
        pick       = last;
        pick_valid = |req;
        for (int off = NUM_CLIENTS; off >= 1; off--) begin
            if (req[(int'(last) + off) % NUM_CLIENTS])
                pick = IDX_W'((int'(last) + off) % NUM_CLIENTS);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state                 <= IDLE;
            last                  <= IDX_W'(NUM_CLIENTS - 1);
            cur                   <= '0;
            wait_cnt              <= '0;
            client_readdata       <= '0;
            client_read_finished  <= '0;
            client_write_finished <= '0;
            rd_timeout            <= 1'b0;
            sdram_address         <= '0;
            sdram_byteenable_n    <= 4'b0000;
            sdram_chipselect      <= 1'b0;
            sdram_writedata       <= '0;
            sdram_read_n          <= 1'b1;
            sdram_write_n         <= 1'b1;
        end else begin
            client_read_finished  <= '0;
            client_write_finished <= '0;
            rd_timeout            <= 1'b0;
            sdram_byteenable_n    <= 4'b0000;

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        cur              <= pick;
                        last             <= pick;
                        sdram_address    <= client_addr[int'(pick)*ADDR_W +: ADDR_W];
                        sdram_writedata  <= client_writedata[int'(pick)*DATA_W +: DATA_W];
                        sdram_chipselect <= 1'b1;
                        if (client_read[pick]) begin
                            sdram_read_n <= 1'b0;
                            state        <= RD_REQ;
                        end else begin
                            sdram_write_n <= 1'b0;
                            state         <= WR_REQ;
                        end
                    end
                end

                RD_REQ: begin
                    if (!sdram_waitrequest) begin
                        sdram_read_n     <= 1'b1;
                        sdram_chipselect <= 1'b0;
                        wait_cnt         <= '0;
                        state            <= RD_WAIT;
                    end
                end

                // Valid data on the final counted cycle still beats the timeout.
                RD_WAIT: begin
                    if (sdram_readdatavalid) begin
                        client_readdata           <= sdram_readdata;
                        client_read_finished[cur] <= 1'b1;
                        state                     <= DONE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        client_readdata           <= '0;
                        rd_timeout                <= 1'b1;
                        client_read_finished[cur] <= 1'b1;
                        state                     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                WR_REQ: begin
                    if (!sdram_waitrequest) begin
                        sdram_write_n              <= 1'b1;
                        sdram_chipselect           <= 1'b0;
                        client_write_finished[cur] <= 1'b1;
                        state                      <= DONE;
                    end
                end

                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
